tl_buffer_6: RTL and testbench

Two-channel TileLink-UL buffer stage sitting directly downstream of the `TLXbar_6` out-port. It sits between that out-port and the slave port it drives. Each direction has an independent circular-buffer queue: the A channel runs master-to-slave and the D channel runs slave-to-master. The queues break the combinational ready/valid paths the crossbar passes straight through. Payload bits are not modified. Ordering within each channel is strict FIFO.

---
 rtl/tl_buffer_6.sv | 224 ++++++++++++++++++++++
 tb/tb_tl_buffer_6.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_buffer_6.sv
// tl_buffer_6: two-channel TileLink-UL buffer stage placed after a crossbar out-port.
// Each direction owns an independent circular-buffer FIFO so that no ready/valid path
// passes combinationally through the stage. Payload bits are carried unmodified.
//
// Ports:
//   clock, reset          - sole clock (rising edge); asynchronous active-low reset
//   auto_in_a_*           - A channel from the master side (ready is an output)
//   auto_out_a_*          - A channel to the slave side (ready is an input)
//   auto_out_d_*          - D channel from the slave side (ready is an output)
//   auto_in_d_*           - D channel to the master side (ready is an input)
//   a_count, d_count      - current occupancy of the A and D queues
module tl_buffer_6 #(
    parameter int unsigned A_DEPTH = 2,
    parameter int unsigned D_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    // A channel, master side
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [6:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic        auto_in_a_bits_user_amba_prot_bufferable,
    input  logic        auto_in_a_bits_user_amba_prot_modifiable,
    input  logic        auto_in_a_bits_user_amba_prot_readalloc,
    input  logic        auto_in_a_bits_user_amba_prot_writealloc,
    input  logic        auto_in_a_bits_user_amba_prot_privileged,
    input  logic        auto_in_a_bits_user_amba_prot_secure,
    input  logic        auto_in_a_bits_user_amba_prot_fetch,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    // D channel, master side
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [6:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic        auto_in_d_bits_corrupt,
    output logic [63:0] auto_in_d_bits_data,
    // A channel, slave side
    input  logic        auto_out_a_ready,
    output logic        auto_out_a_valid,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [6:0]  auto_out_a_bits_source,
    output logic [31:0] auto_out_a_bits_address,
    output logic        auto_out_a_bits_user_amba_prot_bufferable,
    output logic        auto_out_a_bits_user_amba_prot_modifiable,
    output logic        auto_out_a_bits_user_amba_prot_readalloc,
    output logic        auto_out_a_bits_user_amba_prot_writealloc,
    output logic        auto_out_a_bits_user_amba_prot_privileged,
    output logic        auto_out_a_bits_user_amba_prot_secure,
    output logic        auto_out_a_bits_user_amba_prot_fetch,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    // D channel, slave side
    output logic        auto_out_d_ready,
    input  logic        auto_out_d_valid,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [6:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_denied,
    input  logic        auto_out_d_bits_corrupt,
    input  logic [63:0] auto_out_d_bits_data,
    // Occupancy
    output logic [3:0]  a_count,
    output logic [3:0]  d_count
);

    localparam int unsigned AW     = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int unsigned DW     = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam int unsigned A_BITS = 124;
    localparam int unsigned D_BITS = 79;

    if (A_DEPTH < 1 || A_DEPTH > 8) begin : g_bad_a_depth
        $error("A_DEPTH must be in 1..8");
    end
    if (D_DEPTH < 1 || D_DEPTH > 8) begin : g_bad_d_depth
        $error("D_DEPTH must be in 1..8");
    end

    // ------------------------------------------------------------------------
    // A queue (master -> slave)
    // ------------------------------------------------------------------------
    logic [A_BITS-1:0] a_in_beat;
    logic [A_BITS-1:0] a_out_beat;
    // Sized to a power of two so the pointer indexes it exactly; entries at or
    // above A_DEPTH are never written because the pointers wrap at A_DEPTH-1.
    logic [A_BITS-1:0] a_mem_q [2**AW];
    logic [AW-1:0]     a_enq_ptr_q, a_enq_ptr_d;
    logic [AW-1:0]     a_deq_ptr_q, a_deq_ptr_d;
    logic [3:0]        a_count_q, a_count_d;
    logic              a_enq, a_deq;

    assign a_in_beat = {auto_in_a_bits_opcode, auto_in_a_bits_size, auto_in_a_bits_source,
                        auto_in_a_bits_address,
                        auto_in_a_bits_user_amba_prot_bufferable,
                        auto_in_a_bits_user_amba_prot_modifiable,
                        auto_in_a_bits_user_amba_prot_readalloc,
                        auto_in_a_bits_user_amba_prot_writealloc,
                        auto_in_a_bits_user_amba_prot_privileged,
                        auto_in_a_bits_user_amba_prot_secure,
                        auto_in_a_bits_user_amba_prot_fetch,
                        auto_in_a_bits_mask, auto_in_a_bits_data};

    always_comb begin
        auto_in_a_ready  = (a_count_q != 4'(A_DEPTH));
        auto_out_a_valid = (a_count_q != 4'd0);
        a_enq            = auto_in_a_valid && auto_in_a_ready;
        a_deq            = auto_out_a_valid && auto_out_a_ready;

        a_enq_ptr_d = a_enq_ptr_q;
        if (a_enq) begin
            a_enq_ptr_d = (a_enq_ptr_q == AW'(A_DEPTH - 1)) ? '0 : a_enq_ptr_q + AW'(1);
        end
        a_deq_ptr_d = a_deq_ptr_q;
        if (a_deq) begin
            a_deq_ptr_d = (a_deq_ptr_q == AW'(A_DEPTH - 1)) ? '0 : a_deq_ptr_q + AW'(1);
        end

        a_count_d = a_count_q;
        if (a_enq && !a_deq) begin
            a_count_d = a_count_q + 4'd1;
        end else if (a_deq && !a_enq) begin
            a_count_d = a_count_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_enq_ptr_q <= '0;
            a_deq_ptr_q <= '0;
            a_count_q   <= 4'd0;
        end else begin
            a_enq_ptr_q <= a_enq_ptr_d;
            a_deq_ptr_q <= a_deq_ptr_d;
            a_count_q   <= a_count_d;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (a_enq) begin
            a_mem_q[a_enq_ptr_q] <= a_in_beat;
        end
    end

    assign a_out_beat = a_mem_q[a_deq_ptr_q];
    assign {auto_out_a_bits_opcode, auto_out_a_bits_size, auto_out_a_bits_source,
            auto_out_a_bits_address,
            auto_out_a_bits_user_amba_prot_bufferable,
            auto_out_a_bits_user_amba_prot_modifiable,
            auto_out_a_bits_user_amba_prot_readalloc,
            auto_out_a_bits_user_amba_prot_writealloc,
            auto_out_a_bits_user_amba_prot_privileged,
            auto_out_a_bits_user_amba_prot_secure,
            auto_out_a_bits_user_amba_prot_fetch,
            auto_out_a_bits_mask, auto_out_a_bits_data} = a_out_beat;
    assign a_count = a_count_q;

    // ------------------------------------------------------------------------
    // D queue (slave -> master)
    // ------------------------------------------------------------------------
    logic [D_BITS-1:0] d_in_beat;
    logic [D_BITS-1:0] d_out_beat;
    logic [D_BITS-1:0] d_mem_q [2**DW];
    logic [DW-1:0]     d_enq_ptr_q, d_enq_ptr_d;
    logic [DW-1:0]     d_deq_ptr_q, d_deq_ptr_d;
    logic [3:0]        d_count_q, d_count_d;
    logic              d_enq, d_deq;

    assign d_in_beat = {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source,
                        auto_out_d_bits_denied, auto_out_d_bits_corrupt, auto_out_d_bits_data};

    always_comb begin
        auto_out_d_ready = (d_count_q != 4'(D_DEPTH));
        auto_in_d_valid  = (d_count_q != 4'd0);
        d_enq            = auto_out_d_valid && auto_out_d_ready;
        d_deq            = auto_in_d_valid && auto_in_d_ready;

        d_enq_ptr_d = d_enq_ptr_q;
        if (d_enq) begin
            d_enq_ptr_d = (d_enq_ptr_q == DW'(D_DEPTH - 1)) ? '0 : d_enq_ptr_q + DW'(1);
        end
        d_deq_ptr_d = d_deq_ptr_q;
        if (d_deq) begin
            d_deq_ptr_d = (d_deq_ptr_q == DW'(D_DEPTH - 1)) ? '0 : d_deq_ptr_q + DW'(1);
        end

        d_count_d = d_count_q;
        if (d_enq && !d_deq) begin
            d_count_d = d_count_q + 4'd1;
        end else if (d_deq && !d_enq) begin
            d_count_d = d_count_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_enq_ptr_q <= '0;
            d_deq_ptr_q <= '0;
            d_count_q   <= 4'd0;
        end else begin
            d_enq_ptr_q <= d_enq_ptr_d;
            d_deq_ptr_q <= d_deq_ptr_d;
            d_count_q   <= d_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (d_enq) begin
            d_mem_q[d_enq_ptr_q] <= d_in_beat;
        end
    end

    assign d_out_beat = d_mem_q[d_deq_ptr_q];
    assign {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source,
            auto_in_d_bits_denied, auto_in_d_bits_corrupt, auto_in_d_bits_data} = d_out_beat;
    assign d_count = d_count_q;

endmodule

// File: tb/tb_tl_buffer_6.sv
// Bench for tl_buffer_6. Two instances: u_dut0 with default depths and u_dut1 with
// A_DEPTH=3, D_DEPTH=1. Queue index k: 0 = dut0 A, 1 = dut0 D, 2 = dut1 A, 3 = dut1 D.
// A reference model of four plain FIFOs (SV queues) is compared against every DUT
// output on each falling clock edge; directed sections add literal expectations.
module tb_tl_buffer_6;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Stimulus, indexed by queue k (payload always kept in the 124-bit A layout width;
    // D queues use bits [78:0]).
    logic [3:0]   q_vin;
    logic [3:0]   q_rdy;
    logic [123:0] q_bin [4];

    // DUT observations
    wire  [3:0]   rin;
    wire  [3:0]   vout;
    wire  [123:0] ab0, ab2;
    wire  [78:0]  db1, db3;
    wire  [3:0]   cnt0, cnt1, cnt2, cnt3;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned dep [4]     = '{2, 2, 3, 1};
    int unsigned n_enq [4]   = '{0, 0, 0, 0};
    int unsigned dut_deq [4] = '{0, 0, 0, 0};
    logic        chk_en      = 1'b0;
    logic [123:0] mq [4][$];

    tl_buffer_6 #(.A_DEPTH(2), .D_DEPTH(2)) u_dut0 (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(rin[0]), .auto_in_a_valid(q_vin[0]),
        .auto_in_a_bits_opcode(q_bin[0][123:121]), .auto_in_a_bits_size(q_bin[0][120:118]),
        .auto_in_a_bits_source(q_bin[0][117:111]), .auto_in_a_bits_address(q_bin[0][110:79]),
        .auto_in_a_bits_user_amba_prot_bufferable(q_bin[0][78]),
        .auto_in_a_bits_user_amba_prot_modifiable(q_bin[0][77]),
        .auto_in_a_bits_user_amba_prot_readalloc(q_bin[0][76]),
        .auto_in_a_bits_user_amba_prot_writealloc(q_bin[0][75]),
        .auto_in_a_bits_user_amba_prot_privileged(q_bin[0][74]),
        .auto_in_a_bits_user_amba_prot_secure(q_bin[0][73]),
        .auto_in_a_bits_user_amba_prot_fetch(q_bin[0][72]),
        .auto_in_a_bits_mask(q_bin[0][71:64]), .auto_in_a_bits_data(q_bin[0][63:0]),
        .auto_in_d_ready(q_rdy[1]), .auto_in_d_valid(vout[1]),
        .auto_in_d_bits_opcode(db1[78:76]), .auto_in_d_bits_size(db1[75:73]),
        .auto_in_d_bits_source(db1[72:66]), .auto_in_d_bits_denied(db1[65]),
        .auto_in_d_bits_corrupt(db1[64]), .auto_in_d_bits_data(db1[63:0]),
        .auto_out_a_ready(q_rdy[0]), .auto_out_a_valid(vout[0]),
        .auto_out_a_bits_opcode(ab0[123:121]), .auto_out_a_bits_size(ab0[120:118]),
        .auto_out_a_bits_source(ab0[117:111]), .auto_out_a_bits_address(ab0[110:79]),
        .auto_out_a_bits_user_amba_prot_bufferable(ab0[78]),
        .auto_out_a_bits_user_amba_prot_modifiable(ab0[77]),
        .auto_out_a_bits_user_amba_prot_readalloc(ab0[76]),
        .auto_out_a_bits_user_amba_prot_writealloc(ab0[75]),
        .auto_out_a_bits_user_amba_prot_privileged(ab0[74]),
        .auto_out_a_bits_user_amba_prot_secure(ab0[73]),
        .auto_out_a_bits_user_amba_prot_fetch(ab0[72]),
        .auto_out_a_bits_mask(ab0[71:64]), .auto_out_a_bits_data(ab0[63:0]),
        .auto_out_d_ready(rin[1]), .auto_out_d_valid(q_vin[1]),
        .auto_out_d_bits_opcode(q_bin[1][78:76]), .auto_out_d_bits_size(q_bin[1][75:73]),
        .auto_out_d_bits_source(q_bin[1][72:66]), .auto_out_d_bits_denied(q_bin[1][65]),
        .auto_out_d_bits_corrupt(q_bin[1][64]), .auto_out_d_bits_data(q_bin[1][63:0]),
        .a_count(cnt0), .d_count(cnt1)
    );

    tl_buffer_6 #(.A_DEPTH(3), .D_DEPTH(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(rin[2]), .auto_in_a_valid(q_vin[2]),
        .auto_in_a_bits_opcode(q_bin[2][123:121]), .auto_in_a_bits_size(q_bin[2][120:118]),
        .auto_in_a_bits_source(q_bin[2][117:111]), .auto_in_a_bits_address(q_bin[2][110:79]),
        .auto_in_a_bits_user_amba_prot_bufferable(q_bin[2][78]),
        .auto_in_a_bits_user_amba_prot_modifiable(q_bin[2][77]),
        .auto_in_a_bits_user_amba_prot_readalloc(q_bin[2][76]),
        .auto_in_a_bits_user_amba_prot_writealloc(q_bin[2][75]),
        .auto_in_a_bits_user_amba_prot_privileged(q_bin[2][74]),
        .auto_in_a_bits_user_amba_prot_secure(q_bin[2][73]),
        .auto_in_a_bits_user_amba_prot_fetch(q_bin[2][72]),
        .auto_in_a_bits_mask(q_bin[2][71:64]), .auto_in_a_bits_data(q_bin[2][63:0]),
        .auto_in_d_ready(q_rdy[3]), .auto_in_d_valid(vout[3]),
        .auto_in_d_bits_opcode(db3[78:76]), .auto_in_d_bits_size(db3[75:73]),
        .auto_in_d_bits_source(db3[72:66]), .auto_in_d_bits_denied(db3[65]),
        .auto_in_d_bits_corrupt(db3[64]), .auto_in_d_bits_data(db3[63:0]),
        .auto_out_a_ready(q_rdy[2]), .auto_out_a_valid(vout[2]),
        .auto_out_a_bits_opcode(ab2[123:121]), .auto_out_a_bits_size(ab2[120:118]),
        .auto_out_a_bits_source(ab2[117:111]), .auto_out_a_bits_address(ab2[110:79]),
        .auto_out_a_bits_user_amba_prot_bufferable(ab2[78]),
        .auto_out_a_bits_user_amba_prot_modifiable(ab2[77]),
        .auto_out_a_bits_user_amba_prot_readalloc(ab2[76]),
        .auto_out_a_bits_user_amba_prot_writealloc(ab2[75]),
        .auto_out_a_bits_user_amba_prot_privileged(ab2[74]),
        .auto_out_a_bits_user_amba_prot_secure(ab2[73]),
        .auto_out_a_bits_user_amba_prot_fetch(ab2[72]),
        .auto_out_a_bits_mask(ab2[71:64]), .auto_out_a_bits_data(ab2[63:0]),
        .auto_out_d_ready(rin[3]), .auto_out_d_valid(q_vin[3]),
        .auto_out_d_bits_opcode(q_bin[3][78:76]), .auto_out_d_bits_size(q_bin[3][75:73]),
        .auto_out_d_bits_source(q_bin[3][72:66]), .auto_out_d_bits_denied(q_bin[3][65]),
        .auto_out_d_bits_corrupt(q_bin[3][64]), .auto_out_d_bits_data(q_bin[3][63:0]),
        .a_count(cnt2), .d_count(cnt3)
    );

    function automatic logic [123:0] get_bout(input int k);
        case (k)
            0:       return ab0;
            1:       return {45'b0, db1};
            2:       return ab2;
            default: return {45'b0, db3};
        endcase
    endfunction

    function automatic logic [3:0] get_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [123:0] act, input logic [123:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40) begin
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: each queue is a bounded FIFO; a beat is accepted when offered
    // and there is room, the head leaves when the sink is ready. Reset empties all.
    always @(posedge clock or negedge reset) begin
        logic enq, deq;
        if (!reset) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                enq = q_vin[k] && (mq[k].size() < int'(dep[k]));
                deq = q_rdy[k] && (mq[k].size() != 0);
                if (deq) void'(mq[k].pop_front());
                if (enq) begin
                    mq[k].push_back((k % 2 == 1) ? {45'b0, q_bin[k][78:0]} : q_bin[k]);
                    n_enq[k]++;
                end
            end
        end
    end

    // Compare every DUT output against the model, mid-cycle.
    always @(negedge clock) begin
        int sz;
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                sz = mq[k].size();
                chk($sformatf("q%0d_in_ready", k), rin[k], sz != int'(dep[k]));
                chk($sformatf("q%0d_out_valid", k), vout[k], sz != 0);
                chk($sformatf("q%0d_count", k), get_cnt(k), 124'(sz));
                if (sz != 0) chk($sformatf("q%0d_payload", k), get_bout(k), mq[k][0]);
                if (vout[k] && q_rdy[k]) dut_deq[k]++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [123:0] beat;
        logic [127:0] rnd;
        int           cyc;

        q_vin = '0;
        q_rdy = '0;
        for (int k = 0; k < 4; k++) q_bin[k] = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        step();
        chk_en = 1'b1;

        // Reset state
        chk("rst_a_ready", rin[0], 1);
        chk("rst_d_ready", rin[1], 1);
        chk("rst_a_valid", vout[0], 0);
        chk("rst_d_valid", vout[1], 0);
        chk("rst_a_count", cnt0, 0);
        chk("rst_d_count", cnt1, 0);

        // Single A beat: Get to 0x8000_0040, source 0x15, full mask
        beat = {3'd4, 3'd3, 7'h15, 32'h8000_0040, 7'b0, 8'hFF, 64'h0};
        q_rdy[0] = 1'b1;
        q_vin[0] = 1'b1;
        q_bin[0] = beat;
        chk("single_cnt_before", cnt0, 0);
        step();
        q_vin[0] = 1'b0;
        chk("single_valid", vout[0], 1);
        chk("single_beat", ab0, beat);
        chk("single_cnt_mid", cnt0, 1);
        step();
        chk("single_valid_after", vout[0], 0);
        chk("single_cnt_after", cnt0, 0);

        // Full queue, then simultaneous offer and drain
        q_rdy[0] = 1'b0;
        q_vin[0] = 1'b1;
        q_bin[0] = 124'h11;
        step();
        q_bin[0] = 124'h22;
        step();
        chk("full_cnt", cnt0, 2);
        chk("full_ready", rin[0], 0);
        chk("full_head", ab0, 124'h11);
        q_rdy[0] = 1'b1;
        q_bin[0] = 124'h33;
        chk("raise_ready", rin[0], 0);
        step();
        chk("raise_next_ready", rin[0], 1);
        chk("raise_next_cnt", cnt0, 1);
        chk("order_2", ab0, 124'h22);
        step();
        q_vin[0] = 1'b0;
        chk("order_3", ab0, 124'h33);
        chk("order_3_cnt", cnt0, 1);
        step();
        chk("full_drained", cnt0, 0);

        // D streaming, 16 back-to-back beats
        q_rdy[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            q_vin[1] = 1'b1;
            q_bin[1] = 124'(i);
            step();
            chk($sformatf("stream_ready_%0d", i), rin[1], 1);
            chk($sformatf("stream_valid_%0d", i), vout[1], 1);
            chk($sformatf("stream_data_%0d", i), {45'b0, db1}, 124'(i));
        end
        q_vin[1] = 1'b0;
        step();
        chk("stream_drained", cnt1, 0);

        // Channel independence: A stalled full while D flows
        q_rdy[0] = 1'b0;
        q_vin[0] = 1'b1;
        q_bin[0] = 124'hA1;
        step();
        q_bin[0] = 124'hA2;
        step();
        q_vin[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            q_vin[1] = 1'b1;
            q_bin[1] = 124'(100 + i);
            step();
            chk($sformatf("indep_d_data_%0d", i), {45'b0, db1}, 124'(100 + i));
            chk($sformatf("indep_a_cnt_%0d", i), cnt0, 2);
        end

        // Reset with both queues full
        q_rdy[1] = 1'b0;
        q_bin[1] = 124'hD1;
        step();
        q_bin[1] = 124'hD2;
        step();
        q_vin[1] = 1'b0;
        chk("prerst_a_cnt", cnt0, 2);
        chk("prerst_d_cnt", cnt1, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_a_valid", vout[0], 0);
        chk("arst_d_valid", vout[1], 0);
        chk("arst_a_cnt", cnt0, 0);
        chk("arst_d_cnt", cnt1, 0);
        chk("arst_a_ready", rin[0], 1);
        chk("arst_d_ready", rin[1], 1);
        q_rdy = 4'hF;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("stale_a_%0d", i), vout[0], 0);
            chk($sformatf("stale_d_%0d", i), vout[1], 0);
        end

        // Random traffic on all four queues; runs until dut1's depth-3 A queue
        // has accepted 1000 beats.
        for (int k = 0; k < 4; k++) begin
            n_enq[k]   = 0;
            dut_deq[k] = 0;
        end
        cyc = 0;
        while (n_enq[2] < 1000 && cyc < 20000) begin
            for (int k = 0; k < 4; k++) begin
                q_vin[k] = ($urandom_range(0, 3) != 0);
                q_rdy[k] = ($urandom_range(0, 2) != 0);
                rnd = {$urandom, $urandom, $urandom, $urandom};
                q_bin[k] = rnd[123:0];
            end
            step();
            cyc++;
        end
        chk("rand_enq_reached", n_enq[2] >= 1000, 1);
        q_vin = '0;
        q_rdy = 4'hF;
        repeat (10) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rand_delivered_q%0d", k), 124'(dut_deq[k]), 124'(n_enq[k]));
            chk($sformatf("rand_final_cnt_q%0d", k), get_cnt(k), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
